// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for riscv_mem_arbiter: fetch port, load/store port and the RAM port.
// The arbiter uses the slave view; the core/RAM side uses the master view.
interface riscv_mem_arbiter_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   if_req;
  logic [WORD_LENGTH-1:0] if_addr;
  logic                   if_ready;
  logic                   if_rvalid;
  logic [WORD_LENGTH-1:0] if_rdata;
  logic                   if_err;

  logic                   d_req;
  logic                   d_we;
  logic [1:0]             d_size;
  logic [WORD_LENGTH-1:0] d_addr;
  logic [WORD_LENGTH-1:0] d_wdata;
  logic                   d_ready;
  logic                   d_rvalid;
  logic [WORD_LENGTH-1:0] d_rdata;
  logic                   d_err;

  logic                   mem_en;
  logic                   mem_we;
  logic [3:0]             mem_be;
  logic [WORD_LENGTH-1:0] mem_addr;
  logic [WORD_LENGTH-1:0] mem_wdata;
  logic [WORD_LENGTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, if_err,
    output d_ready, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, if_err,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-port RAM arbiter for fetch and load/store: data-first priority with a
// fetch starvation guard, byte-lane store alignment and right-justified loads.
module riscv_mem_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 200,
  parameter int MAX_WAIT    = 4
) (
  input logic                clk,
  input logic                rst,
  riscv_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
  localparam logic [WORD_LENGTH:0] MEM_LIMIT = (WORD_LENGTH + 1)'(NUM_MEM);

  // True when the access would touch a byte at or beyond NUM_MEM.
  function automatic logic out_of_range(input logic [WORD_LENGTH-1:0] addr,
                                        input logic [2:0] nbytes);
    logic [WORD_LENGTH:0] last;
    last = {1'b0, addr} + {{(WORD_LENGTH - 2){1'b0}}, nbytes};
    return last > MEM_LIMIT;
  endfunction

  logic [CW-1:0]          starve_q, starve_d;
  logic                   rsp_if_q, rsp_d_q, rsp_err_q, rsp_we_q;
  logic [1:0]             rsp_size_q, rsp_off_q;

  logic [2:0]             d_bytes_s;
  logic                   d_misal_s;
  logic [3:0]             be_base_s;
  logic                   d_ill_s, if_ill_s;
  logic                   d_win_s, i_win_s, sel_ill_s, sel_we_s, mem_en_s;
  logic [WORD_LENGTH-1:0] sel_addr_s, mem_addr_s, mem_wdata_s;
  logic [3:0]             mem_be_s;
  logic [WORD_LENGTH-1:0] shifted_s, load_s, if_rdata_s, d_rdata_s;

  // Data-port size decode: access width, alignment and store lane pattern.
  always_comb begin
    d_bytes_s = 3'd4;
    d_misal_s = 1'b1;
    be_base_s = 4'b1111;
    case (bus.d_size)
      2'd0: begin
        d_bytes_s = 3'd1;
        d_misal_s = 1'b0;
        be_base_s = 4'b0001;
      end
      2'd1: begin
        d_bytes_s = 3'd2;
        d_misal_s = bus.d_addr[0];
        be_base_s = 4'b0011;
      end
      2'd2: begin
        d_bytes_s = 3'd4;
        d_misal_s = (bus.d_addr[1:0] != 2'b00);
        be_base_s = 4'b1111;
      end
      default: begin
        d_bytes_s = 3'd4;
        d_misal_s = 1'b1;
        be_base_s = 4'b1111;
      end
    endcase
  end

  assign d_ill_s  = d_misal_s | out_of_range(bus.d_addr, d_bytes_s);
  assign if_ill_s = (bus.if_addr[1:0] != 2'b00) | out_of_range(bus.if_addr, 3'd4);

  // Arbitration and RAM command; reset blocks any grant so outputs stay quiet.
  always_comb begin
    d_win_s     = 1'b0;
    i_win_s     = 1'b0;
    sel_ill_s   = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    mem_en_s    = 1'b0;
    mem_be_s    = 4'b0000;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    d_win_s = !rst && bus.d_req && !(bus.if_req && (starve_q == MAX_CNT));
    i_win_s = !rst && bus.if_req && !d_win_s;
    if (d_win_s) begin
      sel_ill_s  = d_ill_s;
      sel_addr_s = bus.d_addr;
      sel_we_s   = bus.d_we;
    end else begin
      sel_ill_s  = if_ill_s;
      sel_addr_s = bus.if_addr;
      sel_we_s   = 1'b0;
    end
    mem_en_s = (d_win_s || i_win_s) && !sel_ill_s;
    if (mem_en_s) begin
      mem_addr_s = {sel_addr_s[WORD_LENGTH-1:2], 2'b00};
      if (sel_we_s) begin
        mem_be_s    = be_base_s << sel_addr_s[1:0];
        mem_wdata_s = bus.d_wdata << {sel_addr_s[1:0], 3'b000};
      end else begin
        mem_be_s    = 4'b1111;
        mem_wdata_s = '0;
      end
    end else begin
      mem_addr_s = '0;
    end
  end

  // Starvation counter next state: counts cycles a pending fetch loses.
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || i_win_s) begin
      starve_d = '0;
    end else if (starve_q != MAX_CNT) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter and response tag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rsp_if_q   <= 1'b0;
      rsp_d_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_we_q   <= 1'b0;
      rsp_size_q <= 2'd0;
      rsp_off_q  <= 2'd0;
    end else begin
      starve_q   <= starve_d;
      rsp_if_q   <= i_win_s;
      rsp_d_q    <= d_win_s;
      rsp_err_q  <= sel_ill_s;
      rsp_we_q   <= sel_we_s;
      rsp_size_q <= bus.d_size;
      rsp_off_q  <= sel_addr_s[1:0];
    end
  end

  // Response data: right-justify the addressed lanes and zero-fill above size.
  always_comb begin
    shifted_s = bus.mem_rdata >> {rsp_off_q, 3'b000};
    load_s    = shifted_s;
    case (rsp_size_q)
      2'd0:    load_s = {{(WORD_LENGTH - 8){1'b0}}, shifted_s[7:0]};
      2'd1:    load_s = {{(WORD_LENGTH - 16){1'b0}}, shifted_s[15:0]};
      default: load_s = shifted_s;
    endcase
    if (rsp_if_q && !rsp_err_q) begin
      if_rdata_s = bus.mem_rdata;
    end else begin
      if_rdata_s = '0;
    end
    if (rsp_d_q && !rsp_err_q && !rsp_we_q) begin
      d_rdata_s = load_s;
    end else begin
      d_rdata_s = '0;
    end
  end

  assign bus.if_ready  = i_win_s;
  assign bus.d_ready   = d_win_s;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_en_s && sel_we_s;
  assign bus.mem_be    = mem_be_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.if_rvalid = rsp_if_q;
  assign bus.if_err    = rsp_if_q && rsp_err_q;
  assign bus.if_rdata  = if_rdata_s;
  assign bus.d_rvalid  = rsp_d_q;
  assign bus.d_err     = rsp_d_q && rsp_err_q;
  assign bus.d_rdata   = d_rdata_s;

endmodule
